// File: rtl/sram_port_arbiter_pkg.sv
// dlx_mem_pkg: shared encodings for the DLX SRAM port arbiter.
//   SZ_BYTE/SZ_HALF/SZ_WORD : d_size encodings (2'b11 is reserved)
//   arb_state_t              : arbiter state encoding
//   WORD_MASK                : clears the byte offset of an address
//   size_err()               : misalignment / reserved-size check
package dlx_mem_pkg;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_DONE
  } arb_state_t;

  function automatic logic size_err(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: size_err = 1'b0;
      SZ_HALF: size_err = lo[0];
      SZ_WORD: size_err = (lo != 2'b00);
      default: size_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sram_port_arbiter_lane.sv
// sram_lane_unit: combinational big-endian lane logic.
//   dout    in  32  word read from SRAM; dout[31:24] is byte 0
//   lo      in  2   byte offset of the access
//   size    in  2   access size
//   sgn     in  1   sign-extend sub-word loads
//   wdata   in  32  right-justified store data
//   ld_data out 32  extracted and extended load result
//   st_word out 32  dout with the addressed lane replaced by wdata
module sram_lane_unit
  import dlx_mem_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    case (lo)
      2'd0:    bsel = dout[31:24];
      2'd1:    bsel = dout[23:16];
      2'd2:    bsel = dout[15:8];
      default: bsel = dout[7:0];
    endcase
    hsel = lo[1] ? dout[15:0] : dout[31:16];

    case (size)
      SZ_BYTE: ld_data = {{24{sgn & bsel[7]}}, bsel};
      SZ_HALF: ld_data = {{16{sgn & hsel[15]}}, hsel};
      default: ld_data = dout;
    endcase
  end

  always_comb begin
    st_word = dout;
    case (size)
      SZ_BYTE: begin
        case (lo)
          2'd0:    st_word[31:24] = wdata[7:0];
          2'd1:    st_word[23:16] = wdata[7:0];
          2'd2:    st_word[15:8]  = wdata[7:0];
          default: st_word[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lo[1]) st_word[15:0]  = wdata[15:0];
        else       st_word[31:16] = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one asynchronous-read SRAM between the DLX
// fetch port (i_*) and the load/store port (d_*). Data has priority; after
// STARVE_LIMIT consecutive data grants with i_req pending, fetch is forced.
//   i_req/i_addr -> i_ack/i_rdata/i_err          fetch port
//   d_req/d_we/d_size/d_signed/d_addr/d_wdata
//                -> d_ack/d_rdata/d_err          data port
//   sram_cs/oe/we/addr/din (registered), sram_dout (async read data)
// sram_dout[31:24] is big-endian byte 0 (bits 0..7 in SRAM numbering).
module sram_port_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned AW           = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic          d_signed,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we,
  output logic [31:0]   sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);

  localparam int unsigned   CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state, state_nx;
  logic [CW-1:0] starve;

  logic        op_data, op_we, op_sgn, op_err;
  logic [1:0]  op_size, op_lo;
  logic [31:0] op_addr, op_wdata;

  logic        any_req, pick_fetch, sub_store;
  logic        cur_data, cur_we, cur_sgn, cur_err;
  logic [1:0]  cur_size, cur_lo;
  logic [31:0] cur_addr, cur_wdata;
  logic [31:0] ld_data, st_word;

  logic        nx_cs, nx_oe, nx_we, nx_iack, nx_ierr, nx_dack, nx_derr;
  logic [31:0] nx_addr, nx_din, nx_irdata, nx_drdata;

  // In IDLE the "current" operation is the one being granted this cycle;
  // afterwards it is the copy latched at the grant edge.
  always_comb begin
    any_req    = i_req | d_req;
    pick_fetch = i_req & (~d_req | (starve == LIMIT));
    if (state == ST_IDLE) begin
      cur_data = ~pick_fetch;
      if (pick_fetch) begin
        cur_we    = 1'b0;
        cur_size  = SZ_WORD;
        cur_sgn   = 1'b0;
        cur_addr  = 32'(i_addr);
        cur_wdata = '0;
        cur_err   = (i_addr[1:0] != 2'b00);
      end else begin
        cur_we    = d_we;
        cur_size  = d_size;
        cur_sgn   = d_signed;
        cur_addr  = 32'(d_addr);
        cur_wdata = d_wdata;
        cur_err   = size_err(d_size, d_addr[1:0]);
      end
    end else begin
      cur_data  = op_data;
      cur_we    = op_we;
      cur_size  = op_size;
      cur_sgn   = op_sgn;
      cur_addr  = op_addr;
      cur_wdata = op_wdata;
      cur_err   = op_err;
    end
    cur_lo    = cur_addr[1:0];
    sub_store = cur_data & cur_we & (cur_size != SZ_WORD) & ~cur_err;
  end

  sram_lane_unit u_lane (
    .dout    (sram_dout),
    .lo      (cur_lo),
    .size    (cur_size),
    .sgn     (cur_sgn),
    .wdata   (cur_wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      starve   <= '0;
      op_data  <= 1'b0;
      op_we    <= 1'b0;
      op_sgn   <= 1'b0;
      op_err   <= 1'b0;
      op_size  <= '0;
      op_lo    <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      sram_cs  <= 1'b0;
      sram_oe  <= 1'b0;
      sram_we  <= 1'b0;
      sram_addr <= '0;
      sram_din <= '0;
      i_ack    <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE) begin
        if (!i_req)           starve <= '0;
        else if (!pick_fetch) starve <= starve + 1'b1;
        else                  starve <= '0;
        if (any_req) begin
          op_data  <= cur_data;
          op_we    <= cur_we;
          op_sgn   <= cur_sgn;
          op_err   <= cur_err;
          op_size  <= cur_size;
          op_lo    <= cur_lo;
          op_addr  <= cur_addr;
          op_wdata <= cur_wdata;
        end
      end
      sram_cs   <= nx_cs;
      sram_oe   <= nx_oe;
      sram_we   <= nx_we;
      sram_addr <= nx_addr;
      sram_din  <= nx_din;
      i_ack     <= nx_iack;
      i_err     <= nx_ierr;
      i_rdata   <= nx_irdata;
      d_ack     <= nx_dack;
      d_err     <= nx_derr;
      d_rdata   <= nx_drdata;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          if (cur_err)        state_nx = ST_DONE;
          else if (sub_store) state_nx = ST_RMW_RD;
          else                state_nx = ST_ACC;
        end
      end
      ST_ACC:    state_nx = ST_DONE;
      ST_RMW_RD: state_nx = ST_RMW_WR;
      ST_RMW_WR: state_nx = ST_DONE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Outputs are computed for the state being entered and registered, so the
  // SRAM sees clean cs/oe/we for the whole cycle. Captures of read data
  // (load result, RMW old word merged into din) happen on the leaving edge.
  always_comb begin
    nx_cs     = 1'b0;
    nx_oe     = 1'b0;
    nx_we     = 1'b0;
    nx_addr   = '0;
    nx_din    = '0;
    nx_iack   = 1'b0;
    nx_ierr   = 1'b0;
    nx_irdata = '0;
    nx_dack   = 1'b0;
    nx_derr   = 1'b0;
    nx_drdata = '0;
    case (state_nx)
      ST_ACC: begin
        nx_cs   = 1'b1;
        nx_oe   = ~cur_we;
        nx_we   = cur_we;
        nx_addr = cur_addr & WORD_MASK;
        nx_din  = cur_wdata;
      end
      ST_RMW_RD: begin
        nx_cs   = 1'b1;
        nx_oe   = 1'b1;
        nx_addr = cur_addr & WORD_MASK;
      end
      ST_RMW_WR: begin
        nx_cs   = 1'b1;
        nx_we   = 1'b1;
        nx_addr = cur_addr & WORD_MASK;
        nx_din  = st_word;
      end
      ST_DONE: begin
        if (cur_data) begin
          nx_dack = 1'b1;
          nx_derr = cur_err;
          if (state == ST_ACC && !cur_we) nx_drdata = ld_data;
        end else begin
          nx_iack = 1'b1;
          nx_ierr = cur_err;
          if (state == ST_ACC) nx_irdata = sram_dout;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_signed, d_ack, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        sram_cs, sram_oe, sram_we;
  logic [31:0] sram_addr, sram_din, sram_dout;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic watch_we = 1'b0;
  logic we_after_rst = 1'b0;

  sram_port_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Async-read SRAM model; bench preloads share the single write port.
  assign sram_dout = mem[sram_addr[9:2]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (sram_cs && sram_we) mem[sram_addr[9:2]] <= sram_din;
  end

  always @(sram_we) if (watch_we && sram_we) we_after_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every ack, in grant order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (i_ack || d_ack)) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected_ack: observed=ack with empty queue expected=no ack");
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_port", {31'd0, d_ack}, {31'd0, e.is_data});
        chk("sb_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
        chk("sb_err", {31'd0, d_ack ? d_err : i_err}, {31'd0, e.err});
      end
    end
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_idx = idx; pl_val = val; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives one request at cycle 0, records cs/oe/we per cycle 0..3 and the
  // write data, checks ack latency, then drops the request after the ack.
  task automatic xact(input string tag, input logic is_data, input logic we,
                      input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int exp_lat, input logic [3:0] exp_cs,
                      input logic [3:0] exp_oe, input logic [3:0] exp_we,
                      input logic [31:0] exp_din);
    logic [3:0]  cs_m, oe_m, we_m;
    logic [31:0] din_seen;
    int lat;
    sb.push_back('{is_data, exp_rdata, exp_err});
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    cs_m = '0; oe_m = '0; we_m = '0; din_seen = '0; lat = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 4) begin
        cs_m[c] = sram_cs; oe_m[c] = sram_oe; we_m[c] = sram_we;
      end
      if (sram_we) din_seen = sram_din;
      if (is_data ? d_ack : i_ack) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0; i_req = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_cs"}, {28'd0, cs_m}, {28'd0, exp_cs});
    chk({tag, "_oe"}, {28'd0, oe_m}, {28'd0, exp_oe});
    chk({tag, "_we"}, {28'd0, we_m}, {28'd0, exp_we});
    if (exp_we != 4'd0) chk({tag, "_din"}, din_seen, exp_din);
  endtask

  logic [134:0] all_out;
  assign all_out = {i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
                    sram_cs, sram_oe, sram_we, sram_addr, sram_din};

  initial begin
    int nd, fetch_at;
    logic got_i;
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = '0; d_signed = 1'b0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_nonzero", {31'd0, |all_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fetch word
    preload(8'd0, 32'h2001AAAA);
    xact("fetch0", 0, 0, W, 0, 32'h00, 0, 32'h2001AAAA, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);

    // Loads over 0xF0F0F0F0 and 0x1234F0F0
    preload(8'd32, 32'hF0F0F0F0);
    xact("lb_u80", 1, 0, B, 0, 32'h80, 0, 32'h000000F0, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);
    xact("lb_s81", 1, 0, B, 1, 32'h81, 0, 32'hFFFFFFF0, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);
    xact("lh_u80", 1, 0, H, 0, 32'h80, 0, 32'h0000F0F0, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);
    preload(8'd32, 32'h1234F0F0);
    xact("lh_s82", 1, 0, H, 1, 32'h82, 0, 32'hFFFFF0F0, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);
    xact("lh_s80", 1, 0, H, 1, 32'h80, 0, 32'h00001234, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);
    xact("lb_s80", 1, 0, B, 1, 32'h80, 0, 32'h00000012, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);
    xact("lb_u83", 1, 0, B, 0, 32'h83, 0, 32'h000000F0, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);
    xact("lw_80",  1, 0, W, 0, 32'h80, 0, 32'h1234F0F0, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);

    // Sub-word stores (read-modify-write) and word store
    preload(8'd32, 32'h11223344);
    xact("sb_82", 1, 1, B, 0, 32'h82, 32'hFFFFFFAB, 0, 0, 3, 4'b0110, 4'b0010, 4'b0100, 32'h1122AB44);
    chk("mem_after_sb", mem[32], 32'h1122AB44);
    xact("sh_80", 1, 1, H, 0, 32'h80, 32'h99995566, 0, 0, 3, 4'b0110, 4'b0010, 4'b0100, 32'h5566AB44);
    chk("mem_after_sh", mem[32], 32'h5566AB44);
    xact("sw_84", 1, 1, W, 0, 32'h84, 32'hDEADBEEF, 0, 0, 2, 4'b0010, 4'b0000, 4'b0010, 32'hDEADBEEF);
    xact("lw_84", 1, 0, W, 0, 32'h84, 0, 32'hDEADBEEF, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);

    // Error cases: no SRAM cycle, ack one cycle after grant
    xact("err_sw0e", 1, 1, W, 0, 32'h0E, 32'h12345678, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    xact("err_rsv",  1, 0, R, 0, 32'h80, 0, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    xact("err_lh81", 1, 0, H, 1, 32'h81, 0, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    xact("err_sh83", 1, 1, H, 0, 32'h83, 32'h1, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    xact("err_if02", 0, 0, W, 0, 32'h02, 0, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, 0);

    // Starvation bound: data continuously re-issued while fetch pends
    preload(8'd32, 32'h0BADF00D);
    for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 32'h0BADF00D, 1'b0});
    sb.push_back('{1'b0, 32'h2001AAAA, 1'b0});
    sb.push_back('{1'b1, 32'h0BADF00D, 1'b0});
    d_req = 1'b1; d_we = 1'b0; d_size = W; d_signed = 1'b0; d_addr = 32'h80;
    i_req = 1'b1; i_addr = 32'h00;
    nd = 0; fetch_at = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      got_i = i_ack;
      if (d_ack) nd++;
      if (got_i) fetch_at = nd;
      @(posedge clk); #1;
      if (got_i) i_req = 1'b0;
      if (nd == 5) begin
        d_req = 1'b0;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("starve_fetch_after", 32'(fetch_at), 32'd4);
    chk("starve_data_acks", 32'(nd), 32'd5);

    // Reset asserted during RMW_RD of a byte store
    preload(8'd32, 32'h11223344);
    d_req = 1'b1; d_we = 1'b1; d_size = B; d_signed = 1'b0; d_addr = 32'h82; d_wdata = 32'h000000CC;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_rd_ctl", {29'd0, sram_cs, sram_oe, sram_we}, 32'b110);
    watch_we = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {31'd0, |all_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_we_pulse", {31'd0, we_after_rst}, 32'd0);
    chk("rst_mem_intact", mem[32], 32'h11223344);
    xact("fetch_post_rst", 0, 0, W, 0, 32'h00, 0, 32'h2001AAAA, 0, 2, 4'b0010, 4'b0010, 4'b0000, 0);
    watch_we = 1'b0;

    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Controller that shares the single-ported asynchronous-read `sram` between the DLX instruction-fetch port and the load/store data port.
- Sequences each access as registered cs/oe/we/addr/din cycles.
- Handles byte and halfword loads with zero or sign extension; sub-word stores use read-modify-write.
- Big-endian: byte offset 0 maps to sram_dout[0:7].
- Data port has priority; a starvation counter bounds the fetch wait.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while i_req is pending before fetch is forced.
- AW, 32: address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  fetch request; held stable until i_ack.
- i_addr  in  AW  fetch byte address.
- i_ack  out  1  one-cycle completion pulse.
- i_rdata  out  32  fetched word; valid while i_ack=1.
- i_err  out  1  misaligned fetch; valid while i_ack=1.
- d_req  in  1  data request; held stable until d_ack.
- d_we  in  1  1=store, 0=load.
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- d_signed  in  1  sign-extend sub-word loads.
- d_addr  in  AW  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  load result; 0 for stores.
- d_err  out  1  misaligned or reserved size; valid while d_ack=1.
- sram_cs, sram_oe, sram_we  out  1 each  SRAM controls.
- sram_addr  out  32  word address; bits [1:0] always 00.
- sram_din  out  32  SRAM write data.
- sram_dout  in  32 ([0:31])  SRAM read data, combinational on addr.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, starve counter=0, every output=0.
  - Any in-flight access is aborted.
  - No sram_we pulse may occur after reset assertion.
- States: IDLE, ACC, RMW_RD, RMW_WR, DONE.
- IDLE arbitration:
  - d_req wins unless i_req is pending and starve count == STARVE_LIMIT; then fetch wins.
  - The counter increments on each data grant while i_req=1.
  - The counter clears on a fetch grant, and whenever i_req=0 in IDLE.
- Error check at grant:
  - Errors: word with addr[1:0]!=0, half with addr[0]=1, d_size=11, or fetch addr[1:0]!=0.
  - Action: IDLE -> DONE directly, with err=1, ack=1, rdata=0, and no cs.
- Word store, or any load/fetch: IDLE -> ACC -> DONE.
  - In ACC: cs=1; oe=!we; we=store; addr=word addr; din=d_wdata.
  - Read data is captured at the ACC->DONE edge.
- Sub-word store: IDLE -> RMW_RD -> RMW_WR -> DONE.
  - RMW_RD: cs=1, oe=1; old word captured at end of cycle.
  - RMW_WR: cs=1, we=1; din=old word with the addressed lane replaced by d_wdata[7:0] or d_wdata[15:0].
- Load lanes:
  - Byte k (addr[1:0]=k) = dout[8k:8k+7].
  - Half at addr[1]=h = dout[16h:16h+15].
  - Result is zero- or sign-extended per d_signed.
- DONE: ack of the granted port asserted for exactly this cycle; all sram_* = 0; no grant this cycle.
  - DONE -> IDLE.
  - The requester must drop or replace req on the edge that samples ack.
- Latency (request seen in IDLE at cycle 0):
  - read/word store: ack at cycle 2.
  - sub-word store: ack at cycle 3.
  - error: ack at cycle 1.
- Simultaneous requests: only one is granted per IDLE; the loser stays pending.
- sram_* outputs are registered; cs is never high in IDLE or DONE.

Decomposition:
- Package dlx_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - arbiter state enum.
  - constant WORD_MASK.
- Sub-module sram_lane_unit (combinational):
  - load extract/extend (dout, addr[1:0], size, signed).
  - store merge (old word, wdata, addr[1:0], size).

Test Plan:
- Fetch from 0x00 with SRAM word 0x2001AAAA -> cs=1, oe=1 in cycle 1 only; i_ack in cycle 2 with i_rdata=0x2001AAAA, i_err=0.
- Unsigned byte load at 0x80 over 0xF0F0F0F0 -> d_rdata=0x000000F0. Signed half load at 0x82 over 0x1234F0F0 -> 0xFFFFF0F0.
- i_req and d_req both high from cycle 0 with data requests continuously re-issued, STARVE_LIMIT=4 -> four data acks, then the fetch ack before the fifth data ack.
- Byte store 0xAB to 0x82 over 0x11223344:
  - RMW_RD at cycle 1 (we=0).
  - RMW_WR at cycle 2 with din=0x1122AB44, we=1.
  - d_ack at cycle 3.
- Word store to 0x0E, and d_size=11 -> d_ack=1, d_err=1 at cycle 1; cs never asserted.
- rst_n low during RMW_RD -> all outputs 0 immediately; no sram_we pulse. After release, a new fetch completes normally.
